// File: rtl/dmem_port_pkg.sv
// rtl/dmem_port_pkg.sv - LC-3b shared types: opcodes, line mask, data-port FSM states and opcode helpers.
package lc3b_types;

    typedef enum logic [3:0] {
        OP_BR   = 4'h0,
        OP_ADD  = 4'h1,
        OP_LDB  = 4'h2,
        OP_STB  = 4'h3,
        OP_JSR  = 4'h4,
        OP_AND  = 4'h5,
        OP_LDR  = 4'h6,
        OP_STR  = 4'h7,
        OP_RTI  = 4'h8,
        OP_NOT  = 4'h9,
        OP_LDI  = 4'hA,
        OP_STI  = 4'hB,
        OP_JMP  = 4'hC,
        OP_SHF  = 4'hD,
        OP_LEA  = 4'hE,
        OP_TRAP = 4'hF
    } lc3b_opcode;

    localparam int LC3B_LINE_W = 128;
    typedef logic [LC3B_LINE_W/8-1:0] lc3b_line_mask;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_IND,
        S_DONE
    } dmem_state_t;

    function automatic logic is_mem_op(input lc3b_opcode op);
        return op inside {OP_LDR, OP_LDB, OP_STR, OP_STB, OP_LDI, OP_STI};
    endfunction

    // STI counts as a store even though its first phase is a pointer read.
    function automatic logic is_store(input lc3b_opcode op);
        return op inside {OP_STR, OP_STB, OP_STI};
    endfunction

    function automatic logic is_indirect(input lc3b_opcode op);
        return op inside {OP_LDI, OP_STI};
    endfunction

endpackage

// File: rtl/dmem_port_lane_select.sv
// rtl/dmem_port_lane_select.sv - Picks the addressed word/byte out of a line and builds the byte-lane mask.
module lane_select #(
    parameter int LINE_W = 128
) (
    input  logic [15:0]         addr,
    input  logic [LINE_W-1:0]   rdata,
    input  logic                byte_op,
    input  logic                write,
    output logic [15:0]         word,
    output logic [7:0]          byte_val,
    output logic [LINE_W/8-1:0] byte_enable
);

    localparam int LANES  = LINE_W / 16;
    localparam int NBYTES = LINE_W / 8;

    logic [15:0] lane;
    logic [15:0] byte_idx;

    // Masking instead of slicing keeps LINE_W=16 (a single lane) legal.
    assign lane     = {1'b0, addr[15:1]} & 16'(LANES - 1);
    assign byte_idx = addr & 16'(NBYTES - 1);

    always_comb begin
        word = '0;
        for (int i = 0; i < LANES; i++) begin
            if (lane == 16'(i)) begin
                word = rdata[i*16 +: 16];
            end
        end
    end

    assign byte_val = addr[0] ? word[15:8] : word[7:0];

    always_comb begin
        byte_enable = '0;
        for (int i = 0; i < NBYTES; i++) begin
            if (!write) begin
                byte_enable[i] = 1'b1;
            end else if (byte_op) begin
                byte_enable[i] = (byte_idx == 16'(i));
            end else begin
                byte_enable[i] = (lane == 16'(i / 2));
            end
        end
    end

endmodule

// File: rtl/dmem_port.sv
// rtl/dmem_port.sv - MEM-stage data port: STB/CYC/ACK line access with byte steering, LDI/STI and ACK timeout.
module dmem_port
    import lc3b_types::*;
#(
    parameter int LINE_W   = 128,
    parameter bit LDB_SEXT = 1'b1,
    parameter int TIMEOUT  = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_ex_mem,
    input  lc3b_opcode          opcode,
    input  logic [15:0]         addr,
    input  logic [15:0]         st_data,
    input  logic                dmem_ack,
    input  logic [LINE_W-1:0]   dmem_rdata,
    output logic [15:0]         dmem_address,
    output logic [LINE_W-1:0]   dmem_wdata,
    output logic [LINE_W/8-1:0] dmem_byte_enable,
    output logic                dmem_stb,
    output logic                dmem_cyc,
    output logic                dmem_we,
    output logic [15:0]         ld_data,
    output logic                mem_stall,
    output logic                dmem_err
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    dmem_state_t         state_q, state_d;
    lc3b_opcode          op_q;
    logic [15:0]         addr_q;
    logic [15:0]         st_q;
    logic [CNT_W-1:0]    wait_q;
    logic [15:0]         ld_q;
    logic                err_q;

    logic                busy, start, ptr_load, final_ack, timeout, load_op;
    logic [15:0]         lane_word, load_result;
    logic [7:0]          lane_byte;
    logic [LINE_W/8-1:0] lane_mask;

    lane_select #(.LINE_W(LINE_W)) u_lane (
        .addr        (addr_q),
        .rdata       (dmem_rdata),
        .byte_op     ((state_q == S_ACC) && (op_q inside {OP_LDB, OP_STB})),
        .write       (dmem_we),
        .word        (lane_word),
        .byte_val    (lane_byte),
        .byte_enable (lane_mask)
    );

    assign busy      = (state_q == S_ACC) || (state_q == S_IND);
    assign start     = !busy && load_ex_mem && is_mem_op(opcode);
    assign ptr_load  = (state_q == S_ACC) && dmem_ack && is_indirect(op_q);
    assign final_ack = busy && dmem_ack && ((state_q == S_IND) || !is_indirect(op_q));
    assign timeout   = busy && !dmem_ack && (TIMEOUT != 0) && (wait_q == CNT_W'(TIMEOUT));
    assign load_op   = !is_store(op_q);

    assign load_result = (op_q != OP_LDB) ? lane_word :
                         LDB_SEXT         ? {{8{lane_byte[7]}}, lane_byte} :
                                            {8'h00, lane_byte};

    // The load result bypasses the register in the ACK cycle so the pipeline can advance on that edge.
    assign ld_data          = (final_ack && load_op) ? load_result : ld_q;
    assign dmem_address     = addr_q;
    assign dmem_wdata       = {(LINE_W/16){st_q}};
    assign dmem_byte_enable = busy ? lane_mask : '0;
    assign dmem_err         = err_q;

    always_comb begin
        state_d   = state_q;
        dmem_stb  = busy;
        dmem_cyc  = busy;
        dmem_we   = ((state_q == S_ACC) && is_store(op_q) && !is_indirect(op_q)) ||
                    ((state_q == S_IND) && (op_q == OP_STI));
        mem_stall = busy && !final_ack;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (load_ex_mem && is_mem_op(opcode)) state_d = S_ACC;
            end
            S_ACC: begin
                if (dmem_ack)     state_d = is_indirect(op_q) ? S_IND : S_DONE;
                else if (timeout) state_d = S_DONE;
            end
            S_IND: begin
                if (dmem_ack || timeout) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_BR;
            addr_q  <= '0;
            st_q    <= '0;
            wait_q  <= '0;
            ld_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start) begin
                op_q   <= opcode;
                addr_q <= (opcode inside {OP_LDB, OP_STB}) ? addr : {addr[15:1], 1'b0};
                st_q   <= st_data;
                wait_q <= '0;
            end else if (ptr_load) begin
                addr_q <= {lane_word[15:1], 1'b0};
                wait_q <= '0;
            end else if (busy && (wait_q != CNT_W'(TIMEOUT))) begin
                wait_q <= wait_q + 1'b1;
            end
            if (final_ack && load_op) begin
                ld_q <= load_result;
            end else if (timeout) begin
                ld_q  <= '0;
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_port.sv
// tb/tb_dmem_port.sv - Randomized and directed bench for dmem_port against a word-memory transaction model.
module tb_dmem_port;
    import lc3b_types::*;

    localparam int LW  = 128;
    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_ex_mem = 1'b0;
    logic        dmem_ack = 1'b0;
    lc3b_opcode  opcode = OP_BR;
    logic [15:0] addr = '0;
    logic [15:0] st_data = '0;
    logic [LW-1:0] rdata;

    logic [15:0]   addr_s, addr_z, ld_s, ld_z, be_s, be_z;
    logic [LW-1:0] wdata_s, wdata_z;
    logic          stb_s, stb_z, cyc_s, cyc_z, we_s, we_z, stall_s, stall_z, err_s, err_z;

    logic [15:0] mem [0:32767];

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic          exp_busy = 1'b0, exp_we = 1'b0, exp_stall = 1'b0, exp_err = 1'b0;
    logic [15:0]   exp_addr = '0, exp_be = '0, exp_ld_s = '0, exp_ld_z = '0;
    logic [LW-1:0] exp_wdata = '0;

    int            t_stalls, t_busy;
    logic [15:0]   t_addr, t_be;
    logic [LW-1:0] t_wd;
    logic          t_we;

    always #5 clk = ~clk;

    dmem_port #(.LINE_W(LW), .LDB_SEXT(1'b1), .TIMEOUT(TMO)) dut_s (
        .clk(clk), .rst(rst), .load_ex_mem(load_ex_mem), .opcode(opcode), .addr(addr),
        .st_data(st_data), .dmem_ack(dmem_ack), .dmem_rdata(rdata), .dmem_address(addr_s),
        .dmem_wdata(wdata_s), .dmem_byte_enable(be_s), .dmem_stb(stb_s), .dmem_cyc(cyc_s),
        .dmem_we(we_s), .ld_data(ld_s), .mem_stall(stall_s), .dmem_err(err_s)
    );

    dmem_port #(.LINE_W(LW), .LDB_SEXT(1'b0), .TIMEOUT(TMO)) dut_z (
        .clk(clk), .rst(rst), .load_ex_mem(load_ex_mem), .opcode(opcode), .addr(addr),
        .st_data(st_data), .dmem_ack(dmem_ack), .dmem_rdata(rdata), .dmem_address(addr_z),
        .dmem_wdata(wdata_z), .dmem_byte_enable(be_z), .dmem_stb(stb_z), .dmem_cyc(cyc_z),
        .dmem_we(we_z), .ld_data(ld_z), .mem_stall(stall_z), .dmem_err(err_z)
    );

    // A line is 8 consecutive words of the memory model, aligned on the line size.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < 8; i++) begin
            rdata[i*16 +: 16] = mem[{addr_s[15:4], 3'b000} + 15'(i)];
        end
    end

    assert property (@(posedge clk) disable iff (rst) !(load_ex_mem && cyc_s));

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && chk_en) begin
            chk("cyc_s",   128'(cyc_s),   128'(exp_busy));
            chk("stb_s",   128'(stb_s),   128'(exp_busy));
            chk("cyc_z",   128'(cyc_z),   128'(exp_busy));
            chk("stb_z",   128'(stb_z),   128'(exp_busy));
            chk("we_s",    128'(we_s),    128'(exp_we));
            chk("we_z",    128'(we_z),    128'(exp_we));
            chk("stall_s", 128'(stall_s), 128'(exp_stall));
            chk("stall_z", 128'(stall_z), 128'(exp_stall));
            chk("err_s",   128'(err_s),   128'(exp_err));
            chk("err_z",   128'(err_z),   128'(exp_err));
            chk("ld_s",    128'(ld_s),    128'(exp_ld_s));
            chk("ld_z",    128'(ld_z),    128'(exp_ld_z));
            if (exp_busy) begin
                chk("addr_s",  128'(addr_s),  128'(exp_addr));
                chk("addr_z",  128'(addr_z),  128'(exp_addr));
                chk("be_s",    128'(be_s),    128'(exp_be));
                chk("be_z",    128'(be_z),    128'(exp_be));
                chk("wdata_s", 128'(wdata_s), 128'(exp_wdata));
                chk("wdata_z", 128'(wdata_z), 128'(exp_wdata));
            end else begin
                chk("be_idle_s", 128'(be_s), 128'(0));
                chk("be_idle_z", 128'(be_z), 128'(0));
            end
        end
    end

    function automatic bit tb_mem_op(input lc3b_opcode op);
        return op == OP_LDR || op == OP_LDB || op == OP_STR ||
               op == OP_STB || op == OP_LDI || op == OP_STI;
    endfunction

    // One instruction: the load cycle, then each access phase with ACK after d cycles of waiting.
    task automatic run_txn(input lc3b_opcode op, input logic [15:0] a, input logic [15:0] sd,
                           input int d1, input int d2);
        logic [15:0] paddr, ptr, wd, res_s, res_z;
        logic [7:0]  b;
        bit          ind, st, fin, ack, done;
        int          d;
        t_stalls = 0;
        t_busy   = 0;
        load_ex_mem = 1'b1;
        opcode   = op;
        addr     = a;
        st_data  = sd;
        dmem_ack = 1'($urandom_range(0, 1));
        @(negedge clk);
        @(posedge clk); #1;
        load_ex_mem = 1'b0;
        dmem_ack    = 1'b0;
        if (!tb_mem_op(op)) return;
        ind   = (op == OP_LDI) || (op == OP_STI);
        st    = (op == OP_STR) || (op == OP_STB) || (op == OP_STI);
        paddr = (op == OP_LDB || op == OP_STB) ? a : (a & 16'hFFFE);
        ptr   = '0;
        done  = 1'b0;
        for (int ph = 0; ph < 2 && !done; ph++) begin
            fin = (ph == 1) || !ind;
            d   = (ph == 0) ? d1 : d2;
            if (ph == 1) paddr = ptr;
            for (int w = 0; w < 64 && !done; w++) begin
                ack       = (w == d);
                exp_busy  = 1'b1;
                exp_addr  = paddr;
                exp_we    = (ph == 1) ? (op == OP_STI) : (op == OP_STR || op == OP_STB);
                if (!exp_we)             exp_be = 16'hFFFF;
                else if (op == OP_STB)   exp_be = 16'h0001 << paddr[3:0];
                else                     exp_be = 16'h0003 << {paddr[3:1], 1'b0};
                exp_wdata = {8{sd}};
                exp_stall = !(ack && fin);
                wd    = mem[paddr[15:1]];
                b     = paddr[0] ? wd[15:8] : wd[7:0];
                res_s = (op == OP_LDB) ? {{8{b[7]}}, b} : wd;
                res_z = (op == OP_LDB) ? {8'h00, b} : wd;
                if (ack && fin && !st) begin
                    exp_ld_s = res_s;
                    exp_ld_z = res_z;
                end
                dmem_ack = ack;
                @(negedge clk);
                t_stalls += int'(stall_s);
                t_busy++;
                t_addr = addr_s;
                t_be   = be_s;
                t_wd   = wdata_s;
                t_we   = we_s;
                @(posedge clk); #1;
                dmem_ack = 1'b0;
                if (ack) begin
                    if (!fin) begin
                        ptr = wd & 16'hFFFE;
                    end else begin
                        if (op == OP_STB) begin
                            if (paddr[0]) mem[paddr[15:1]][15:8] = sd[15:8];
                            else          mem[paddr[15:1]][7:0]  = sd[7:0];
                        end else if (st) begin
                            mem[paddr[15:1]] = sd;
                        end
                        done = 1'b1;
                    end
                    break;
                end else if (w == TMO) begin
                    exp_ld_s = '0;
                    exp_ld_z = '0;
                    exp_err  = 1'b1;
                    done     = 1'b1;
                end
            end
        end
        exp_busy  = 1'b0;
        exp_we    = 1'b0;
        exp_stall = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            load_ex_mem = 1'b0;
            dmem_ack    = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        dmem_ack = 1'b0;
    endtask

    function automatic int rdelay();
        return ($urandom_range(0, 9) == 0) ? 9 : int'($urandom_range(0, 3));
    endfunction

    task automatic random_block(input int n);
        lc3b_opcode op;
        for (int k = 0; k < n; k++) begin
            case (int'($urandom_range(0, 9)))
                0:       op = OP_LDR;
                1:       op = OP_LDB;
                2:       op = OP_STR;
                3:       op = OP_STB;
                4:       op = OP_LDI;
                5:       op = OP_STI;
                default: op = lc3b_opcode'(4'($urandom_range(0, 15)));
            endcase
            run_txn(op, 16'($urandom), 16'($urandom), rdelay(), rdelay());
            idle(int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);

        @(negedge clk);
        chk("rst_cyc",   128'(cyc_s),   128'(0));
        chk("rst_stb",   128'(stb_s),   128'(0));
        chk("rst_we",    128'(we_s),    128'(0));
        chk("rst_addr",  128'(addr_s),  128'(0));
        chk("rst_wdata", 128'(wdata_s), 128'(0));
        chk("rst_be",    128'(be_s),    128'(0));
        chk("rst_ld",    128'(ld_s),    128'(0));
        chk("rst_stall", 128'(stall_s), 128'(0));
        chk("rst_err",   128'(err_s),   128'(0));
        @(posedge clk); #1;
        rst    = 1'b0;
        chk_en = 1'b1;
        idle(1);

        mem[16'h0803] = 16'hBEEF;
        run_txn(OP_LDR, 16'h1006, 16'h0000, 0, 0);
        chk("t1_ld",     128'(ld_s),     128'(16'hBEEF));
        chk("t1_stalls", 128'(t_stalls), 128'(0));
        chk("t1_be",     128'(t_be),     128'(16'hFFFF));

        run_txn(OP_STB, 16'h2003, 16'h12AB, 0, 0);
        chk("t2_we",    128'(t_we), 128'(1));
        chk("t2_be",    128'(t_be), 128'(16'h0008));
        chk("t2_wdata", t_wd,       128'h12AB12AB12AB12AB12AB12AB12AB12AB);

        mem[16'h0002] = 16'h8011;
        run_txn(OP_LDB, 16'h0005, 16'h0000, 0, 0);
        chk("t3_ld_sext", 128'(ld_s), 128'(16'hFF80));
        chk("t3_ld_zext", 128'(ld_z), 128'(16'h0080));

        mem[16'h0080] = 16'h3001;
        mem[16'h1800] = 16'h5555;
        run_txn(OP_LDI, 16'h0100, 16'h0000, 2, 2);
        chk("t4_addr2",  128'(t_addr),   128'(16'h3000));
        chk("t4_ld",     128'(ld_s),     128'(16'h5555));
        chk("t4_stalls", 128'(t_stalls), 128'(5));

        idle(1);
        random_block(250);

        run_txn(OP_STR, 16'h4242, 16'h9999, 100, 0);
        chk("t5_busy", 128'(t_busy), 128'(TMO + 1));
        @(negedge clk);
        chk("t5_cyc",   128'(cyc_s),   128'(0));
        chk("t5_err",   128'(err_s),   128'(1));
        chk("t5_ld",    128'(ld_s),    128'(0));
        chk("t5_stall", 128'(stall_s), 128'(0));
        @(posedge clk); #1;

        chk_en      = 1'b0;
        load_ex_mem = 1'b1;
        opcode      = OP_STI;
        addr        = 16'h0200;
        st_data     = 16'h7777;
        dmem_ack    = 1'b0;
        @(posedge clk); #1;
        load_ex_mem = 1'b0;
        dmem_ack    = 1'b1;
        @(posedge clk); #1;
        dmem_ack    = 1'b0;
        @(negedge clk);
        chk("t6_ind_cyc", 128'(cyc_s), 128'(1));
        chk("t6_ind_we",  128'(we_s),  128'(1));
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_cyc",   128'(cyc_s),   128'(0));
        chk("t6_rst_stb",   128'(stb_s),   128'(0));
        chk("t6_rst_we",    128'(we_s),    128'(0));
        chk("t6_rst_stall", 128'(stall_s), 128'(0));
        chk("t6_rst_err",   128'(err_s),   128'(0));
        @(posedge clk); #1;
        rst      = 1'b0;
        exp_ld_s = '0;
        exp_ld_z = '0;
        exp_err  = 1'b0;
        chk_en   = 1'b1;
        mem[16'h2222] = 16'hA5C3;
        run_txn(OP_LDR, 16'h4445, 16'h0000, 1, 0);
        chk("t6_ld", 128'(ld_s), 128'(16'hA5C3));

        idle(1);
        random_block(100);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
